// File: rtl/conv2_pkg.sv
// conv2_pkg
// Shared definitions for the layer-2 convolution window path: filter
// geometry, default pixel width, pixel word type and the line-buffer
// depth helper.
package conv2_pkg;

    localparam int FILTER_SIZE = 5;
    localparam int DATA_BITS   = 12;

    typedef logic [DATA_BITS-1:0] pixel_t;

    // Entries needed so the oldest tap of a 5x5 window is still held:
    // four full rows plus one window width.
    function automatic int tap_depth(input int width);
        return (FILTER_SIZE - 1) * width + FILTER_SIZE;
    endfunction

endpackage

// File: rtl/conv2_shift_reg.sv
// conv2_shift_reg
// Enable-gated shift register exposing every entry in parallel.
// Entry 0 holds the most recently shifted-in word.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset, clears all entries
//   i_en       shift enable
//   i_data     word shifted into entry 0
//   o_entries  all entries, [0] newest .. [DEPTH-1] oldest
module conv2_shift_reg #(
    parameter int DEPTH = 53,
    parameter int W     = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic [W-1:0]             i_data,
    output logic [DEPTH-1:0][W-1:0]  o_entries
);

    logic [DEPTH-1:0][W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_en)
            r_q <= {r_q[DEPTH-2:0], i_data};
    end

    assign o_entries = r_q;

endmodule

// File: rtl/conv2_window_buf.sv
// conv2_window_buf
// Streaming 5x5 sliding-window generator. Pixels arrive in raster order;
// for each fully populated window the 25 taps are presented together with
// a one-cycle valid_out_buf strobe, one cycle after the qualifying pixel.
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   valid_in, data_in           pixel stream, one pixel per high cycle
//   data_out_0 .. data_out_24   taps, k = row k/5, col k%5 (24 = newest)
//   valid_out_buf               taps hold a complete window
//   frame_done                  last pixel of the frame was accepted
module conv2_window_buf #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic [DATA_BITS-1:0] data_out_0,  data_out_1,  data_out_2,
    output logic [DATA_BITS-1:0] data_out_3,  data_out_4,  data_out_5,
    output logic [DATA_BITS-1:0] data_out_6,  data_out_7,  data_out_8,
    output logic [DATA_BITS-1:0] data_out_9,  data_out_10, data_out_11,
    output logic [DATA_BITS-1:0] data_out_12, data_out_13, data_out_14,
    output logic [DATA_BITS-1:0] data_out_15, data_out_16, data_out_17,
    output logic [DATA_BITS-1:0] data_out_18, data_out_19, data_out_20,
    output logic [DATA_BITS-1:0] data_out_21, data_out_22, data_out_23,
    output logic [DATA_BITS-1:0] data_out_24,
    output logic                 valid_out_buf,
    output logic                 frame_done
);
    import conv2_pkg::*;

    localparam int TAP_DEPTH = tap_depth(WIDTH);
    localparam int NTAPS     = FILTER_SIZE * FILTER_SIZE;
    localparam int CW        = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0]                           r_col;
    logic [RW-1:0]                           r_row;
    logic [TAP_DEPTH-1:0][DATA_BITS-1:0]     w_sr;
    logic [NTAPS-1:0][DATA_BITS-1:0]         w_next;
    logic [NTAPS-1:0][DATA_BITS-1:0]         r_taps;
    logic                                    w_last_col;
    logic                                    w_last_row;
    logic                                    w_win_ok;
    logic                                    w_unused_oldest;

    conv2_shift_reg #(.DEPTH(TAP_DEPTH), .W(DATA_BITS)) u_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (valid_in),
        .i_data   (data_in),
        .o_entries(w_sr)
    );

    // Taps are registered on the same edge the pixel shifts in, so they are
    // taken from the post-shift view: post-shift entry 0 is data_in and
    // post-shift entry i is current entry i-1. The current oldest entry is
    // therefore shifted out without ever being a tap.
    assign w_unused_oldest = ^w_sr[TAP_DEPTH-1];

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam int R   = k / FILTER_SIZE;
        localparam int C   = k % FILTER_SIZE;
        localparam int IDX = (FILTER_SIZE-1-R) * WIDTH + (FILTER_SIZE-1-C);
        if (IDX == 0) begin : g_new
            assign w_next[k] = data_in;
        end else begin : g_old
            assign w_next[k] = w_sr[IDX-1];
        end
    end

    assign w_last_col = (r_col == CW'(WIDTH-1));
    assign w_last_row = (r_row == RW'(HEIGHT-1));
    // Windows with col < 4 straddle a row boundary; rows < 4 are incomplete.
    assign w_win_ok   = (r_row >= RW'(FILTER_SIZE-1)) && (r_col >= CW'(FILTER_SIZE-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col         <= '0;
            r_row         <= '0;
            r_taps        <= '0;
            valid_out_buf <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            valid_out_buf <= valid_in && w_win_ok;
            frame_done    <= valid_in && w_last_col && w_last_row;
            if (valid_in) begin
                r_taps <= w_next;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign data_out_0  = r_taps[0];
    assign data_out_1  = r_taps[1];
    assign data_out_2  = r_taps[2];
    assign data_out_3  = r_taps[3];
    assign data_out_4  = r_taps[4];
    assign data_out_5  = r_taps[5];
    assign data_out_6  = r_taps[6];
    assign data_out_7  = r_taps[7];
    assign data_out_8  = r_taps[8];
    assign data_out_9  = r_taps[9];
    assign data_out_10 = r_taps[10];
    assign data_out_11 = r_taps[11];
    assign data_out_12 = r_taps[12];
    assign data_out_13 = r_taps[13];
    assign data_out_14 = r_taps[14];
    assign data_out_15 = r_taps[15];
    assign data_out_16 = r_taps[16];
    assign data_out_17 = r_taps[17];
    assign data_out_18 = r_taps[18];
    assign data_out_19 = r_taps[19];
    assign data_out_20 = r_taps[20];
    assign data_out_21 = r_taps[21];
    assign data_out_22 = r_taps[22];
    assign data_out_23 = r_taps[23];
    assign data_out_24 = r_taps[24];

endmodule

// File: doc/conv2_window_buf.md
# conv2_window_buf

Streaming 5×5 sliding-window generator for one input channel of the second convolution layer. It accepts the pooled layer-1 feature map one 12-bit pixel at a time in raster order and holds the last four rows plus five pixels in a shift-register line buffer. For every fully-populated window position, it presents all 25 taps in parallel with a single-cycle `valid_out_buf` strobe. Three instances, one per input channel, feed the layer-2 convolution-sum calculators.

## Interface
- `WIDTH`, default 12: feature-map columns (≥ FILTER_SIZE).
- `HEIGHT`, default 12: feature-map rows (≥ FILTER_SIZE).
- `DATA_BITS`, default 12: pixel width, unsigned.
- `clk`  in  1: clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `valid_in`  in  1: `data_in` is valid this cycle; each high cycle consumes one pixel.
- `data_in`  in  DATA_BITS: pixel, raster order (row-major, column 0 first).
- `data_out_0` … `data_out_24`  out  DATA_BITS each: window taps; tap k = row k/5, column k%5; `data_out_0` is top-left, `data_out_24` is bottom-right (newest pixel).
- `valid_out_buf`  out  1: one-cycle strobe; taps hold a complete window.
- `frame_done`  out  1: one-cycle strobe after the last pixel of a frame is accepted.

## Operation
- Line buffer: shift register of depth TAP_DEPTH = (FILTER_SIZE−1)·WIDTH + FILTER_SIZE (53 at defaults).
  - Shifts only on `valid_in`; entry 0 = newest.
  - Tap (r,c) = entry (4−r)·WIDTH + (4−c).
- Counters `col` (0..WIDTH−1) and `row` (0..HEIGHT−1) give the position of the pixel being accepted. They advance on `valid_in` only.
  - `col` wraps at WIDTH−1 and increments `row`.
  - At (HEIGHT−1, WIDTH−1) both wrap to 0.
- Window valid condition: accepted pixel has `row` ≥ 4 and `col` ≥ 4. Positions with `col` < 4 straddle a row boundary and are suppressed.
- Windows per frame: (WIDTH−4)·(HEIGHT−4), which is 64 at defaults.
- Taps are registered and hold their value when `valid_in` is low. No arithmetic and no sign extension: data passes through bit-exact.
- `valid_in` low (bubble): no shift, counters and outputs held, `valid_out_buf` = 0.
- Back-to-back frames: the counter wrap starts the next frame immediately. Stale previous-frame data in the buffer is harmless because the validity gating suppresses it.
- Reset (asynchronous, any time, including mid-frame):
  - Counters 0.
  - Shift register 0.
  - All `data_out_*` 0.
  - `valid_out_buf` 0, `frame_done` 0.
  - After release, the next accepted pixel is (0,0).

## Timing
- Latency: 1 cycle. `valid_out_buf` and the matching taps appear on the rising edge after the cycle in which the qualifying pixel is accepted.
- Throughput: one pixel per cycle, no backpressure. With continuous `valid_in`, `valid_out_buf` is high for 8 consecutive cycles per qualifying row, then low for 4.
- `frame_done` asserts in the same cycle as the final window's `valid_out_buf`.
- No ready signal: the upstream block must not stall mid-pixel. The downstream block must sample taps on the strobe cycle.

## Structure
- Shared package `conv2_pkg`:
  - FILTER_SIZE = 5, DATA_BITS = 12.
  - Function or localparam computing TAP_DEPTH from WIDTH.
  - Typedef for a pixel word.
- Sub-module `conv2_shift_reg`: parameterised depth/width, enable-gated shift register exposing all entries. The top level holds the counters, validity logic and output registers.

## Test plan
- Ramp frame: `data_in` = row·16 + col, continuous `valid_in`.
  - First `valid_out_buf` on the cycle after the 53rd pixel.
  - `data_out_0` = 0x000, `data_out_12` = 0x022, `data_out_24` = 0x044.
  - Exactly 64 strobes, last with `data_out_24` = 0x0BB, coincident with `frame_done`.
- Row-boundary gating: same ramp. No strobe after pixels (5,0)…(5,3). Strobe after (5,4) with `data_out_0` = 0x010.
- Random bubbles: `valid_in` toggled pseudo-randomly at 50%.
  - Same 64 windows in the same order as the ramp case.
  - Taps unchanged during every bubble.
- Reset mid-frame: assert `rst_n` = 0 asynchronously after pixel 30.
  - All outputs 0 immediately.
  - After release, a full ramp frame again yields 64 correct windows.
- Back-to-back frames: two ramp frames, the second offset by +0x100.
  - 128 strobes total.
  - Second frame's first window `data_out_0` = 0x100.
  - `frame_done` pulses exactly twice.
